// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types and result constants for the divider-sharing controller.
package div_share_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
   typedef logic owner_t;
   localparam logic [7:0] DIVZERO_Q = 8'hFF;
   localparam logic [7:0] OVF_Q = 8'h7F;
endpackage

// File: rtl/div_share_ctrl_divider.sv
// Divider8bit: combinational 8-bit signed divider, quotient truncated toward zero, remainder as magnitude.
module Divider8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] q,
   output logic [7:0] r,
   output logic       err
);
   logic [7:0] am, bm, bs, qm;
   assign am = a[7] ? -a : a;
   assign bm = b[7] ? -b : b;
   assign bs = (bm == 8'd0) ? 8'd1 : bm;
   assign qm = am / bs;
   assign r = am % bs;
   assign q = (a[7] ^ b[7]) ? -qm : qm;
   assign err = b == 8'd0;
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sharing of one Divider8bit between two requesters.
// Optional DIV_OVF_DET_EN saturates -128 / -1 to 0x7F with the error flag set.
module div_share_ctrl
   import div_share_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   input  logic [W-1:0]    req_a0,
   input  logic [W-1:0]    req_b0,
   input  logic [W-1:0]    req_a1,
   input  logic [W-1:0]    req_b1,
   output logic [NREQ-1:0] rsp_valid,
   input  logic [NREQ-1:0] rsp_ready,
   output logic [W-1:0]    rsp_q,
   output logic [W-1:0]    rsp_r,
   output logic            rsp_err
);
   state_t state;
   owner_t owner, last;
   logic [W-1:0] opa, opb, dq, dr, nq, nr;
   logic [NREQ-1:0] gnt;
   logic zero, ovf, nerr;
   Divider8bit u_div (.a(opa), .b(opb), .q(dq), .r(dr), .err());
   always_comb begin
      gnt[0] = req_valid[0] & (~req_valid[1] | last);
      gnt[1] = req_valid[1] & (~req_valid[0] | ~last);
      req_ready = (state == IDLE && !rst) ? gnt : '0;
      zero = opb == '0;
`ifdef DIV_OVF_DET_EN
      ovf = opa == 8'h80 && opb == 8'hFF;
`else
      ovf = 1'b0;
`endif
      nq = zero ? DIVZERO_Q : ovf ? OVF_Q : dq;
      // remainder takes the dividend's sign
      nr = zero ? opa : ovf ? '0 : opa[W-1] ? -dr : dr;
      nerr = zero | ovf;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= 1'b0;
         last <= 1'b1;
         opa <= '0;
         opb <= '0;
         rsp_valid <= '0;
         rsp_q <= '0;
         rsp_r <= '0;
         rsp_err <= 1'b0;
      end else if (state == IDLE && |gnt) begin
         opa <= gnt[1] ? req_a1 : req_a0;
         opb <= gnt[1] ? req_b1 : req_b0;
         owner <= gnt[1];
         last <= gnt[1];
         state <= CALC;
      end else if (state == CALC) begin
         rsp_q <= nq;
         rsp_r <= nr;
         rsp_err <= nerr;
         rsp_valid <= owner ? 2'b10 : 2'b01;
         state <= RESP;
      end else if (state == RESP && rsp_ready[owner]) begin
         rsp_valid <= '0;
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed self-checking bench for div_share_ctrl.
module tb_div_share_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
   logic [7:0] req_a0, req_b0, req_a1, req_b1, rsp_q, rsp_r;
   logic rsp_err;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   div_share_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic run0(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ee);
      req_valid = 2'b01;
      req_a0 = a;
      req_b0 = b;
      #1 chk({tag, "_ready"}, req_ready, 2'b01);
      step;
      req_valid = 2'b00;
      chk({tag, "_calc_valid"}, rsp_valid, 2'b00);
      step;
      chk({tag, "_valid"}, rsp_valid, 2'b01);
      chk({tag, "_q"}, rsp_q, eq);
      chk({tag, "_r"}, rsp_r, er);
      chk({tag, "_err"}, rsp_err, ee);
      rsp_ready = 2'b01;
      step;
      chk({tag, "_done"}, rsp_valid, 2'b00);
      rsp_ready = 2'b00;
   endtask
   initial begin
      logic [1:0] g;
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a0 = 8'h00; req_b0 = 8'h00; req_a1 = 8'h00; req_b1 = 8'h00;
      @(negedge clk);
      req_valid = 2'b11;
      #1 chk("rst_ready", req_ready, 2'b00);
      req_valid = 2'b00;
      step;
      step;
      rst = 1'b0;
      step;
      chk("reset_valid", rsp_valid, 2'b00);
      chk("reset_q", rsp_q, 8'h00);
      chk("reset_r", rsp_r, 8'h00);
      chk("reset_err", rsp_err, 1'b0);
      chk("reset_ready", req_ready, 2'b00);
      run0("single", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
      // last grant was requester 0, so the tie sequence starts at 1
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      req_a0 = 8'h0D; req_b0 = 8'h03;
      req_a1 = 8'h64; req_b1 = 8'hF6;
      g = 2'b10;
      for (int i = 0; i < 4; i++) begin
         #1 chk("rr_grant", req_ready, g);
         step;
         chk("rr_calc_ready", req_ready, 2'b00);
         step;
         chk("rr_valid", rsp_valid, g);
         chk("rr_q", rsp_q, g[1] ? 8'hF6 : 8'h04);
         chk("rr_r", rsp_r, g[1] ? 8'h00 : 8'h01);
         chk("rr_err", rsp_err, 1'b0);
         step;
         g = {g[0], g[1]};
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      run0("divzero", 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1);
      req_valid = 2'b01;
      req_a0 = 8'h13; req_b0 = 8'h05;
      rsp_ready = 2'b10;
      step;
      step;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", rsp_valid, 2'b01);
         chk("bp_q", rsp_q, 8'h03);
         chk("bp_r", rsp_r, 8'h04);
         chk("bp_ready", req_ready, 2'b00);
         step;
      end
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      step;
      chk("bp_done", rsp_valid, 2'b00);
      rsp_ready = 2'b00;
`ifdef DIV_OVF_DET_EN
      run0("ovf", 8'h80, 8'hFF, 8'h7F, 8'h00, 1'b1);
`else
      run0("ovf", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
`endif
      // requester 0 owns the aborted op, so only a pointer reset gives the next tie to 0
      req_valid = 2'b01;
      req_a0 = 8'h55; req_b0 = 8'h05;
      step;
      rst = 1'b1;
      req_valid = 2'b11;
      #1 chk("midrst_ready", req_ready, 2'b00);
      step;
      chk("midrst_valid", rsp_valid, 2'b00);
      chk("midrst_q", rsp_q, 8'h00);
      rst = 1'b0;
      #1 chk("midrst_tie", req_ready, 2'b01);
      step;
      chk("midrst_after_valid", rsp_valid, 2'b00);
      req_valid = 2'b00;
      step;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
